// File: rtl/mmi_pkg.sv
// Shared definitions for the memory-mapped interconnect: address map, target select codes, FSM states.
package mmi_pkg;

    // Inclusive byte-address windows of the three targets.
    localparam logic [31:0] RAM_LO  = 32'h0000_0000;
    localparam logic [31:0] RAM_HI  = 32'h0000_0003;
    localparam logic [31:0] CP_LO   = 32'h0000_0014;
    localparam logic [31:0] CP_HI   = 32'h0000_0017;
    localparam logic [31:0] COMM_LO = 32'h0000_0018;
    localparam logic [31:0] COMM_HI = 32'h0000_001B;

    localparam logic [2:0] SEL_RAM  = 3'b100;
    localparam logic [2:0] SEL_CP   = 3'b010;
    localparam logic [2:0] SEL_COMM = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mmi_addr_decode.sv
// Combinational address decoder: byte address -> one-hot target select plus mapped flag.
module mmi_addr_decode
    import mmi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [2:0]        sel_o,
    output logic              mapped_o
);

    // Offset-from-base compare: one unsigned test covers both bounds, and an
    // address below the base wraps to a large offset that fails it.
    function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                    input logic [31:0] lo, input logic [31:0] hi);
        logic [ADDR_W-1:0] off;
        off = a - ADDR_W'(lo);
        return off <= ADDR_W'(hi - lo);
    endfunction

    always_comb begin
        sel_o = SEL_NONE;
        if (in_win(addr_i, RAM_LO, RAM_HI))
            sel_o = SEL_RAM;
        else if (in_win(addr_i, CP_LO, CP_HI))
            sel_o = SEL_CP;
        else if (in_win(addr_i, COMM_LO, COMM_HI))
            sel_o = SEL_COMM;
    end

    assign mapped_o = |sel_o;

endmodule

// File: rtl/mmi_rsp_mux.sv
// Read/ack return path: one request at a time, strobes the decoded target, returns data or a timeout/unmapped error.
module mmi_rsp_mux
    import mmi_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    output logic [2:0]        o_sel,
    output logic              o_sel_valid,
    input  logic [DATA_W-1:0] i_rdata_ram,
    input  logic [DATA_W-1:0] i_rdata_cp,
    input  logic [DATA_W-1:0] i_rdata_comm,
    input  logic              i_rvalid_ram,
    input  logic              i_rvalid_cp,
    input  logic              i_rvalid_comm,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    input  logic              i_rsp_ready
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [2:0]        dec_sel;
    logic              dec_mapped;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    mmi_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .addr_i   (i_req_addr),
        .sel_o    (dec_sel),
        .mapped_o (dec_mapped)
    );

    // Only the selected target's rvalid counts; strays from the other two are ignored.
    assign hit = |(sel_q & {i_rvalid_ram, i_rvalid_cp, i_rvalid_comm});

    always_comb begin
        hit_data = '0;
        if (sel_q[2])
            hit_data = i_rdata_ram;
        else if (sel_q[1])
            hit_data = i_rdata_cp;
        else if (sel_q[0])
            hit_data = i_rdata_comm;
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        we_d        = we_q;
        data_d      = data_q;
        err_d       = err_q;
        timer_d     = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d = i_req_we;
                    if (dec_mapped) begin
                        sel_d       = dec_sel;
                        sel_valid_d = 1'b1;
                        timer_d     = '0;
                        state_d     = ST_WAIT;
                    end else begin
                        data_d  = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle still wins over the timeout.
                if (hit) begin
                    data_d  = we_q ? '0 : hit_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    sel_d   = SEL_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_NONE;
            sel_valid_q <= 1'b0;
            we_q        <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            we_q        <= we_d;
            data_q      <= data_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_sel       = sel_q;
    assign o_sel_valid = sel_valid_q;
    assign o_rsp_data  = data_q;
    assign o_rsp_err   = err_q;

endmodule
